grf_wb_trace: RTL and testbench

- General register file (GRF) that receives the writeback stream: register write address, write data, write enable, and the PC of the retiring instruction.
- Provides two combinational read ports with same-cycle write bypass.
- Records every accepted write in a small trace FIFO, drained by the simulation/trace sink through a valid/ready handshake.
- Sits at the end of the writeback datapath in the single-cycle CPU and is the sole owner of architectural register state.

---
 rtl/grf_wb_trace.sv | 124 ++++++++++++
 tb/tb_grf_wb_trace.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_trace.sv
// Architectural register file fed by the writeback stream, with two bypassed
// combinational read ports and a small trace FIFO drained by a valid/ready sink.
module grf_wb_trace #(
    parameter int TRACE_DEPTH = 4,
    parameter int PTR_W       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic [4:0]  RegWriteAddr,
    input  logic [31:0] RegWriteData,
    input  logic [31:0] WbPC,
    input  logic [4:0]  RA1,
    input  logic [4:0]  RA2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_addr,
    output logic [31:0] trace_data,
    output logic        trace_full,
    output logic        trace_overflow
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(TRACE_DEPTH);

    // ---------------- register file ----------------
    logic [31:0] regs_q [32];
    logic        reg_we;
    logic        byp_en;

    assign reg_we = RegWrite && (RegWriteAddr != 5'd0);
    // Bypass is suppressed while reset is held so reads are 0 immediately.
    assign byp_en = RegWrite && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (reg_we) begin
            regs_q[RegWriteAddr] <= RegWriteData;
        end
    end

    always_comb begin
        RD1 = '0;
        if (RA1 != 5'd0)
            RD1 = (byp_en && RegWriteAddr == RA1) ? RegWriteData : regs_q[RA1];
    end

    always_comb begin
        RD2 = '0;
        if (RA2 != 5'd0)
            RD2 = (byp_en && RegWriteAddr == RA2) ? RegWriteData : regs_q[RA2];
    end

    // ---------------- trace FIFO ----------------
    logic [31:0]      pc_mem_q   [TRACE_DEPTH];
    logic [4:0]       addr_mem_q [TRACE_DEPTH];
    logic [31:0]      data_mem_q [TRACE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             fifo_valid, fifo_full;
    logic             push, pop, drop;

    assign fifo_valid = (count_q != '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign pop        = fifo_valid && trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push       = RegWrite && (!fifo_full || pop);
    assign drop       = RegWrite && fifo_full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | drop;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                addr_mem_q[i] <= '0;
                data_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]   <= WbPC;
            addr_mem_q[wr_ptr_q] <= RegWriteAddr;
            data_mem_q[wr_ptr_q] <= RegWriteData;
        end
    end

    assign trace_valid    = fifo_valid;
    assign trace_full     = fifo_full;
    assign trace_overflow = ovf_q;
    assign trace_pc       = fifo_valid ? pc_mem_q[rd_ptr_q]   : '0;
    assign trace_addr     = fifo_valid ? addr_mem_q[rd_ptr_q] : '0;
    assign trace_data     = fifo_valid ? data_mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_grf_wb_trace.sv
// Bench for grf_wb_trace: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue/array model.
module tb_grf_wb_trace;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        RegWrite = 1'b0;
    logic [4:0]  RegWriteAddr = '0;
    logic [31:0] RegWriteData = '0;
    logic [31:0] WbPC = '0;
    logic [4:0]  RA1 = '0;
    logic [4:0]  RA2 = '0;
    logic [31:0] RD1, RD2;
    logic        trace_valid;
    logic        trace_ready = 1'b0;
    logic [31:0] trace_pc;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic        trace_full;
    logic        trace_overflow;

    grf_wb_trace #(.TRACE_DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .RegWrite(RegWrite), .RegWriteAddr(RegWriteAddr),
        .RegWriteData(RegWriteData), .WbPC(WbPC),
        .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data),
        .trace_full(trace_full), .trace_overflow(trace_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    logic [31:0] m_regs [32];
    ent_t        mq [$];
    bit          m_ovf;
    bit          m_pop;
    ent_t        m_ent;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            m_pop = (mq.size() != 0) && trace_ready;
            if (RegWrite && RegWriteAddr != 5'd0) m_regs[RegWriteAddr] = RegWriteData;
            if (m_pop) void'(mq.pop_front());
            if (RegWrite) begin
                if (mq.size() < DEPTH) begin
                    m_ent.pc = WbPC; m_ent.addr = RegWriteAddr; m_ent.data = RegWriteData;
                    mq.push_back(m_ent);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (ra == 5'd0) return '0;
        if (RegWrite && RegWriteAddr == ra) return RegWriteData;
        return m_regs[ra];
    endfunction

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (reset) begin
            check("rd1", RD1, exp_rd(RA1));
            check("rd2", RD2, exp_rd(RA2));
            check("valid", trace_valid, mq.size() != 0);
            check("full", trace_full, mq.size() == DEPTH);
            check("ovf", trace_overflow, m_ovf);
            check("head_pc",   trace_pc,   (mq.size() != 0) ? mq[0].pc   : 32'd0);
            check("head_addr", trace_addr, (mq.size() != 0) ? mq[0].addr : 5'd0);
            check("head_data", trace_data, (mq.size() != 0) ? mq[0].data : 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic we, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                         input logic rdy);
        @(posedge clk); #1;
        RegWrite = we; RegWriteAddr = a; RegWriteData = d; WbPC = pc;
        RA1 = r1; RA2 = r2; trace_ready = rdy;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    int rdy_bias;

    initial begin
        // Reset then read
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        drive(0, 0, 0, 0, 5, 31, 0);
        sample();
        check("rst_rd1", RD1, 32'd0);
        check("rst_rd2", RD2, 32'd0);
        check("rst_valid", trace_valid, 1'b0);
        check("rst_ovf", trace_overflow, 1'b0);

        // Write and bypass
        drive(1, 8, 32'h1234_5678, 32'h3000, 8, 0, 0);
        sample();
        check("byp_rd1", RD1, 32'h1234_5678);
        drive(0, 0, 0, 0, 8, 0, 0);
        sample();
        check("reg_rd1", RD1, 32'h1234_5678);
        check("wr_valid", trace_valid, 1'b1);
        check("wr_pc", trace_pc, 32'h3000);
        check("wr_addr", trace_addr, 5'd8);
        check("wr_data", trace_data, 32'h1234_5678);
        drive(0, 0, 0, 0, 8, 0, 1);
        drive(0, 0, 0, 0, 8, 0, 0);

        // $0 write
        drive(1, 0, 32'hFFFF_FFFF, 32'h4000, 0, 0, 0);
        sample();
        check("z_rd1_wr", RD1, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        sample();
        check("z_rd1", RD1, 32'd0);
        check("z_valid", trace_valid, 1'b1);
        check("z_addr", trace_addr, 5'd0);
        check("z_data", trace_data, 32'hFFFF_FFFF);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        sample();
        check("z_drained", trace_valid, 1'b0);

        // Fill and overflow
        for (int k = 1; k <= 5; k++) begin
            drive(1, 5'(k), 32'(k), 32'h100 + 32'(k * 4), 5, 0, 0);
            sample();
            if (k == 5) begin
                check("fill_full", trace_full, 1'b1);
                check("fill_noovf", trace_overflow, 1'b0);
            end
        end
        drive(0, 0, 0, 0, 5, 0, 0);
        sample();
        check("ovf_reg5", RD1, 32'd5);
        check("ovf_set", trace_overflow, 1'b1);
        check("ovf_full", trace_full, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 0, 0, 5, 0, 1);
            sample();
            check("drain_addr", trace_addr, 5'(k));
        end
        drive(0, 0, 0, 0, 5, 0, 0);
        sample();
        check("drain_empty", trace_valid, 1'b0);
        check("ovf_sticky", trace_overflow, 1'b1);

        // Full with simultaneous push/pop
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        for (int k = 10; k <= 13; k++) drive(1, 5'(k), 32'hA0 + 32'(k), 32'h5000 + 32'(k), 0, 0, 0);
        drive(1, 9, 32'h99, 32'h9000, 9, 0, 1);
        sample();
        check("pp_full_pre", trace_full, 1'b1);
        drive(0, 0, 0, 0, 9, 0, 1);
        sample();
        check("pp_full_post", trace_full, 1'b1);
        check("pp_noovf", trace_overflow, 1'b0);
        check("pp_head", trace_addr, 5'd11);
        check("pp_reg9", RD1, 32'h99);
        drive(0, 0, 0, 0, 9, 0, 1);
        sample();
        check("pp_head2", trace_addr, 5'd12);
        drive(0, 0, 0, 0, 9, 0, 1);
        sample();
        check("pp_head3", trace_addr, 5'd13);
        drive(0, 0, 0, 0, 9, 0, 1);
        sample();
        check("pp_last_addr", trace_addr, 5'd9);
        check("pp_last_data", trace_data, 32'h99);
        drive(0, 0, 0, 0, 9, 0, 0);
        sample();
        check("pp_empty", trace_valid, 1'b0);

        // Reset mid-stream
        drive(1, 20, 32'hD20, 32'h6000, 21, 22, 0);
        drive(1, 21, 32'hD21, 32'h6004, 21, 22, 0);
        drive(1, 22, 32'hD22, 32'h6008, 21, 22, 0);
        drive(0, 0, 0, 0, 21, 22, 0);
        sample();
        check("mid_pre_rd1", RD1, 32'hD21);
        check("mid_pre_valid", trace_valid, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("mid_valid", trace_valid, 1'b0);
        check("mid_full", trace_full, 1'b0);
        check("mid_rd1", RD1, 32'd0);
        check("mid_rd2", RD2, 32'd0);
        @(posedge clk); #1 reset = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rdy_bias = ((i / 300) % 2 == 0) ? 2 : 8;
            @(posedge clk); #1;
            RegWrite     = ($urandom_range(0, 3) != 0);
            RegWriteAddr = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            RegWriteData = $urandom;
            WbPC         = $urandom;
            RA1          = ($urandom_range(0, 3) == 0) ? RegWriteAddr : 5'($urandom_range(0, 7));
            RA2          = ($urandom_range(0, 3) == 0) ? RegWriteAddr : 5'($urandom_range(0, 31));
            trace_ready  = ($urandom_range(0, 9) < rdy_bias);
            reset        = ($urandom_range(0, 399) != 0);
        end
        @(posedge clk); #1 reset = 1'b1; RegWrite = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
